// File: rtl/barrett_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// barrett_seq_ctrl_pkg
//   Shared definitions for the Barrett modular-multiplication sequencer.
//   - state_t     : sequencer states (IDLE, CLEAR, ITER, FINAL, DONE)
//   - DEF_*       : default operand/digit/final-stage sizing
//   - ITERS       : digit iterations per operation for the default sizing
//   - ITER_W      : width of the iteration index for the default sizing
//   - FIN_W       : width of the FINAL down-counter for the default sizing
//   - cnt_width() : counter width helper, never returns less than 1 bit
// -----------------------------------------------------------------------------
package barrett_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ITER  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_N       = 1024;
  localparam int DEF_M       = 4;
  localparam int DEF_FIN_CYC = 3;

  localparam int ITERS  = DEF_N / DEF_M;
  localparam int ITER_W = $clog2(ITERS);
  localparam int FIN_W  = $clog2(DEF_FIN_CYC + 1);

  // Width able to index 0..v-1 (or hold v-1); a single-value range still
  // needs one physical bit.
  function automatic int cnt_width(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/barrett_digit_shifter.sv
// -----------------------------------------------------------------------------
// barrett_digit_shifter
//   Holds an N-bit operand and presents it M bits at a time, most-significant
//   digit first. Loading takes priority over shifting.
//   CLK   in   clock
//   RST   in   asynchronous active-low reset (register cleared to 0)
//   load  in   capture d_in at the next edge
//   shift in   shift left by M (zero fill) at the next edge
//   d_in  in   N-bit operand
//   digit out  top M bits of the held operand
// -----------------------------------------------------------------------------
module barrett_digit_shifter #(
  parameter int N = 1024,
  parameter int M = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d_in,
  output logic [M-1:0] digit
);

  logic [N-1:0] sh_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= d_in;
    end else if (shift) begin
      sh_q <= sh_q << M;
    end
  end

  assign digit = sh_q[N-1 -: M];

endmodule

// File: rtl/barrett_seq_ctrl.sv
// -----------------------------------------------------------------------------
// barrett_seq_ctrl
//   Sequencer for a digit-serial Barrett modular multiplier. An accepted START
//   latches the operands, clears the ZS/ZC accumulator for one cycle, streams
//   Y most-significant digit first for N/M cycles, grants FIN_CYC cycles to the
//   final CPA/correction stage and then holds DONE until RES_ACK. ABORT returns
//   to IDLE from any busy state without issuing DONE.
//
//   CLK, RST           clock, asynchronous active-low reset
//   START, ABORT       operation request / cancel
//   RES_ACK            consumer took the result (sampled in DONE only)
//   X_IN, Y_IN, M_IN   N-bit operands and modulus, valid with START
//   MU_IN              (M+7)-bit Barrett constant, valid with START
//   X_Q, M_Q, MU_Q     latched operands to the datapath
//   Y_I                current multiplier digit (0 outside ITER)
//   DP_CLR, DP_EN      accumulator clear / update enable
//   FIN_EN             final-stage enable
//   ITER_IDX           current iteration, 0 = most-significant digit
//   BUSY, DONE         not idle / result valid
//   All outputs come from registers or from the state register only.
// -----------------------------------------------------------------------------
module barrett_seq_ctrl
  import barrett_seq_ctrl_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int FIN_CYC = DEF_FIN_CYC
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         ABORT,
  input  logic                         RES_ACK,
  input  logic [N-1:0]                 X_IN,
  input  logic [N-1:0]                 Y_IN,
  input  logic [N-1:0]                 M_IN,
  input  logic [M+6:0]                 MU_IN,
  output logic [N-1:0]                 X_Q,
  output logic [N-1:0]                 M_Q,
  output logic [M+6:0]                 MU_Q,
  output logic [M-1:0]                 Y_I,
  output logic                         DP_CLR,
  output logic                         DP_EN,
  output logic                         FIN_EN,
  output logic [cnt_width(N/M)-1:0]    ITER_IDX,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int             NUM_ITERS = N / M;
  localparam int             IW        = cnt_width(NUM_ITERS);
  localparam int             FW        = cnt_width(FIN_CYC + 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_ITERS - 1);
  localparam logic [FW-1:0]  FIN_LOAD  = FW'(FIN_CYC);
  localparam logic [FW-1:0]  FIN_LAST  = FW'(1);

  state_t         state_q;
  state_t         state_d;
  logic [FW-1:0]  fin_q;
  logic [M-1:0]   y_top;
  logic           accept;

  // A request is taken only from IDLE, and ABORT in the same cycle wins.
  assign accept = (state_q == S_IDLE) && START && !ABORT;

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)                state_d = S_CLEAR;
      S_CLEAR:                            state_d = S_ITER;
      S_ITER:  if (ITER_IDX == LAST_IDX)  state_d = S_FINAL;
      S_FINAL: if (fin_q == FIN_LAST)     state_d = S_DONE;
      S_DONE:  if (RES_ACK)               state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
    if (ABORT && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State, counters and all control outputs; outputs are derived from the
  // next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      ITER_IDX <= '0;
      fin_q    <= '0;
      BUSY     <= 1'b0;
      DP_CLR   <= 1'b0;
      DP_EN    <= 1'b0;
      FIN_EN   <= 1'b0;
      DONE     <= 1'b0;
      X_Q      <= '0;
      M_Q      <= '0;
      MU_Q     <= '0;
    end else begin
      state_q <= state_d;
      BUSY    <= (state_d != S_IDLE);
      DP_CLR  <= (state_d == S_CLEAR);
      DP_EN   <= (state_d == S_ITER);
      FIN_EN  <= (state_d == S_FINAL);
      DONE    <= (state_d == S_DONE);

      // Advances only while staying in ITER, so it parks on the last index
      // when leaving for FINAL; cleared whenever a new operation can begin.
      if ((state_q == S_ITER) && (state_d == S_ITER)) begin
        ITER_IDX <= ITER_IDX + 1'b1;
      end else if ((state_d == S_IDLE) || (state_d == S_CLEAR)) begin
        ITER_IDX <= '0;
      end

      // FINAL lasts exactly FIN_CYC cycles: load on entry, leave at 1.
      if ((state_q != S_FINAL) && (state_d == S_FINAL)) begin
        fin_q <= FIN_LOAD;
      end else if (state_d == S_FINAL) begin
        fin_q <= fin_q - 1'b1;
      end else begin
        fin_q <= '0;
      end

      if (accept) begin
        X_Q  <= X_IN;
        M_Q  <= M_IN;
        MU_Q <= MU_IN;
      end
    end
  end

  barrett_digit_shifter #(
    .N (N),
    .M (M)
  ) u_y_shifter (
    .CLK   (CLK),
    .RST   (RST),
    .load  (accept),
    .shift (state_q == S_ITER),
    .d_in  (Y_IN),
    .digit (y_top)
  );

  assign Y_I = (state_q == S_ITER) ? y_top : '0;

endmodule
